// File: rtl/jtdsp16_ram_arb_if.sv
// ============================================================================
// Module   : jtdsp16_ram_arb_if
// Purpose  : Bus bundle between the DSP16 core ports, host port and data RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface jtdsp16_ram_arb_if #(
  parameter int AW = 11,
  parameter int DW = 16
);
  logic          cen;
  logic          cendiv;
  logic          cpu_stall;

  logic [AW-1:0] xa_addr;
  logic [DW-1:0] xa_din;
  logic          xa_rd;
  logic          xa_we;
  logic [DW-1:0] xa_dout;

  logic [AW-1:0] yb_addr;
  logic [DW-1:0] yb_din;
  logic          yb_rd;
  logic          yb_we;
  logic [DW-1:0] yb_dout;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_din;
  logic          host_ack;
  logic [DW-1:0] host_dout;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  modport master (
    output cen,
    output xa_addr, xa_din, xa_rd, xa_we,
    output yb_addr, yb_din, yb_rd, yb_we,
    output host_req, host_we, host_addr, host_din,
    output ram_dout,
    input  cendiv, cpu_stall,
    input  xa_dout, yb_dout,
    input  host_ack, host_dout,
    input  ram_addr, ram_din, ram_we
  );

  modport slave (
    input  cen,
    input  xa_addr, xa_din, xa_rd, xa_we,
    input  yb_addr, yb_din, yb_rd, yb_we,
    input  host_req, host_we, host_addr, host_din,
    input  ram_dout,
    output cendiv, cpu_stall,
    output xa_dout, yb_dout,
    output host_ack, host_dout,
    output ram_addr, ram_din, ram_we
  );
endinterface

`default_nettype wire

// File: rtl/jtdsp16_ram_arb.sv
// ============================================================================
// Module   : jtdsp16_ram_arb
// Purpose  : Two-slot DSP16 data RAM scheduler with bounded-wait host access.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jtdsp16_ram_arb #(
  parameter int AW      = 11,
  parameter int DW      = 16,
  parameter int MAXWAIT = 4
) (
  input logic               clk,
  input logic               rst,
  jtdsp16_ram_arb_if.slave  bus
);

  localparam logic [3:0] c_MAXWAIT = 4'(MAXWAIT);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STEAL = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OW_NONE = 2'd0,
    OW_X    = 2'd1,
    OW_Y    = 2'd2,
    OW_H    = 2'd3
  } owner_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [3:0]    r_wait_cnt;
  logic [3:0]    w_wait_nx;
  logic          r_phase;
  logic          r_cendiv;
  logic          r_stall;
  logic          r_xtag;
  logic          r_ytag;
  logic          r_htag;
  logic          r_hrd;
  logic          r_host_ack;
  logic [DW-1:0] r_xdout;
  logic [DW-1:0] r_ydout;
  logic [DW-1:0] r_hdout;
  logic [AW-1:0] r_addr_last;
  logic [DW-1:0] r_din_last;

  owner_t        w_owner;
  logic          w_steal;
  logic          w_x_act;
  logic          w_y_act;
  logic          w_host_ok;
  logic          w_slot_b;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_din;
  logic          w_we;

  assign w_x_act  = bus.xa_rd | bus.xa_we;
  assign w_y_act  = bus.yb_rd | bus.yb_we;
  assign w_slot_b = bus.cen & r_phase;
  // A granted host transaction stays masked until its ack clock has passed
  assign w_host_ok = bus.host_req & ~r_htag & ~r_host_ack;

  // Slot ownership and arbitration state
  always_comb begin
    w_owner    = OW_NONE;
    w_steal    = 1'b0;
    w_state_nx = r_state;
    w_wait_nx  = r_wait_cnt;
    if (!rst) begin
      if (!r_phase) begin
        if (w_x_act) w_owner = OW_X;
      end else if (r_state == ST_STEAL && w_host_ok) begin
        w_owner = OW_H;
        w_steal = 1'b1;
      end else if (w_y_act) begin
        w_owner = OW_Y;
      end else if (w_host_ok) begin
        w_owner = OW_H;
      end
      if (w_slot_b) begin
        case (r_state)
          ST_RUN: begin
            if (w_y_act) begin
              if (w_host_ok) begin
                w_wait_nx = r_wait_cnt + 4'd1;
                if (w_wait_nx == c_MAXWAIT) w_state_nx = ST_STEAL;
              end
            end else if (w_host_ok) begin
              w_wait_nx = 4'd0;
            end
          end
          ST_STEAL: begin
            w_wait_nx  = 4'd0;
            w_state_nx = ST_RUN;
          end
          default: w_state_nx = ST_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nx;
      r_wait_cnt <= w_wait_nx;
    end
  end

  // RAM drive; address and data hold when nobody owns the slot
  always_comb begin
    w_addr = r_addr_last;
    w_din  = r_din_last;
    w_we   = 1'b0;
    case (w_owner)
      OW_X: begin
        w_addr = bus.xa_addr;
        w_din  = bus.xa_din;
        w_we   = bus.xa_we;
      end
      OW_Y: begin
        w_addr = bus.yb_addr;
        w_din  = bus.yb_din;
        w_we   = bus.yb_we;
      end
      OW_H: begin
        w_addr = bus.host_addr;
        w_din  = bus.host_din;
        w_we   = bus.host_we;
      end
      default: ;
    endcase
  end

  assign bus.ram_addr  = w_addr;
  assign bus.ram_din   = w_din;
  assign bus.ram_we    = w_we & bus.cen;
  assign bus.cendiv    = r_cendiv;
  assign bus.cpu_stall = r_stall;
  assign bus.xa_dout   = r_xdout;
  assign bus.yb_dout   = r_ydout;
  assign bus.host_dout = r_hdout;
  assign bus.host_ack  = r_host_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase     <= 1'b0;
      r_cendiv    <= 1'b0;
      r_stall     <= 1'b0;
      r_xtag      <= 1'b0;
      r_ytag      <= 1'b0;
      r_htag      <= 1'b0;
      r_hrd       <= 1'b0;
      r_host_ack  <= 1'b0;
      r_xdout     <= '0;
      r_ydout     <= '0;
      r_hdout     <= '0;
      r_addr_last <= '0;
      r_din_last  <= '0;
    end else begin
      if (bus.cen) begin
        r_phase <= ~r_phase;
        if (w_owner != OW_NONE) begin
          r_addr_last <= w_addr;
          r_din_last  <= w_din;
        end
      end
      r_cendiv <= w_slot_b & ~w_steal;
      if (w_slot_b) r_stall <= w_steal;
      // Read tags live one clock; a write on the same port suppresses capture
      r_xtag     <= bus.cen & (w_owner == OW_X) & ~bus.xa_we;
      r_ytag     <= bus.cen & (w_owner == OW_Y) & ~bus.yb_we;
      r_htag     <= bus.cen & (w_owner == OW_H);
      r_hrd      <= bus.cen & (w_owner == OW_H) & ~bus.host_we;
      r_host_ack <= r_htag;
      if (r_xtag) r_xdout <= bus.ram_dout;
      if (r_ytag) r_ydout <= bus.ram_dout;
      if (r_hrd)  r_hdout <= bus.ram_dout;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtdsp16_ram_arb.sv
// ============================================================================
// Module   : tb_jtdsp16_ram_arb
// Purpose  : Directed self-checking bench for the DSP16 RAM slot scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_jtdsp16_ram_arb;
  localparam int AW = 11;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  jtdsp16_ram_arb_if #(.AW(AW), .DW(DW)) bus ();

  jtdsp16_ram_arb #(.AW(AW), .DW(DW), .MAXWAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single-port synchronous RAM, read-old-data on write
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[11'h010] = 16'h1234;
    mem[11'h030] = 16'h5A5A;
    mem[11'h040] = 16'h1111;
    mem[11'h041] = 16'h2222;

    rst = 1'b1;
    bus.cen = 1'b0;
    bus.xa_addr = '0; bus.xa_din = '0; bus.xa_rd = 1'b0; bus.xa_we = 1'b0;
    bus.yb_addr = '0; bus.yb_din = '0; bus.yb_rd = 1'b0; bus.yb_we = 1'b0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_din = '0;

    tick(); tick(); tick();
    chk("rst_cendiv",  32'(bus.cendiv),    32'd0);
    chk("rst_stall",   32'(bus.cpu_stall), 32'd0);
    chk("rst_ack",     32'(bus.host_ack),  32'd0);
    chk("rst_we",      32'(bus.ram_we),    32'd0);
    chk("rst_xdout",   32'(bus.xa_dout),   32'd0);
    chk("rst_ydout",   32'(bus.yb_dout),   32'd0);
    chk("rst_hdout",   32'(bus.host_dout), 32'd0);
    chk("rst_addr",    32'(bus.ram_addr),  32'd0);
    chk("rst_din",     32'(bus.ram_din),   32'd0);

    // Idle run: cendiv on every second cen, starting at the second
    rst = 1'b0;
    bus.cen = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("idle_cendiv", 32'(bus.cendiv), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("idle_we",     32'(bus.ram_we), 32'd0);
    end

    // X read in slot A, Y write in slot B
    bus.xa_rd = 1'b1; bus.xa_addr = 11'h010;
    bus.yb_we = 1'b1; bus.yb_addr = 11'h020; bus.yb_din = 16'hBEEF;
    #1;
    chk("x_addr_slotA", 32'(bus.ram_addr), 32'h010);
    chk("x_rd_no_we",   32'(bus.ram_we),   32'd0);
    tick();
    bus.xa_rd = 1'b0;
    #1;
    chk("y_addr_slotB", 32'(bus.ram_addr), 32'h020);
    chk("y_we_slotB",   32'(bus.ram_we),   32'd1);
    chk("y_din_slotB",  32'(bus.ram_din),  32'hBEEF);
    tick();
    bus.yb_we = 1'b0;
    chk("x_dout",       32'(bus.xa_dout),  32'h1234);
    chk("y_write_ram",  32'(mem[11'h020]), 32'hBEEF);
    chk("xy_no_ack",    32'(bus.host_ack), 32'd0);

    // Host read with idle Y
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 11'h030;
    tick();
    tick();
    chk("h_ack_early",  32'(bus.host_ack),  32'd0);
    tick();
    chk("h_dout",       32'(bus.host_dout), 32'h5A5A);
    chk("h_ack_pulse",  32'(bus.host_ack),  32'd1);
    bus.host_req = 1'b0;
    tick();
    chk("h_ack_single", 32'(bus.host_ack),  32'd0);
    chk("h_wait_zero",  32'(dut.r_wait_cnt), 32'd0);

    // Y busy every cycle, host write pending: four CPU wins then a steal
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 11'h050; bus.host_din = 16'hCAFE;
    bus.yb_rd = 1'b1; bus.yb_addr = 11'h020;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      chk("busy_cendiv", 32'(bus.cendiv),     32'd1);
      chk("busy_stall",  32'(bus.cpu_stall),  32'd0);
      chk("busy_wait",   32'(dut.r_wait_cnt), 32'(k + 1));
    end
    chk("steal_state",  32'(dut.r_state), 32'd1);
    tick();
    chk("steal_addr",   32'(bus.ram_addr), 32'h050);
    chk("steal_we",     32'(bus.ram_we),   32'd1);
    tick();
    chk("steal_cendiv", 32'(bus.cendiv),     32'd0);
    chk("steal_stall",  32'(bus.cpu_stall),  32'd1);
    chk("steal_write",  32'(mem[11'h050]),   32'hCAFE);
    chk("steal_wait0",  32'(dut.r_wait_cnt), 32'd0);
    tick();
    chk("steal_ack",    32'(bus.host_ack),  32'd1);
    chk("stall_hold",   32'(bus.cpu_stall), 32'd1);
    bus.host_req = 1'b0;
    #1;
    chk("y_reissue",    32'(bus.ram_addr),  32'h020);
    tick();
    chk("post_cendiv",  32'(bus.cendiv),    32'd1);
    chk("post_stall",   32'(bus.cpu_stall), 32'd0);
    tick();
    chk("y_dout",       32'(bus.yb_dout),   32'hBEEF);
    chk("post_ack",     32'(bus.host_ack),  32'd0);
    bus.yb_rd = 1'b0;
    tick();

    // host_req held across two transactions
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 11'h040;
    tick();
    tick();
    tick();
    chk("b2b_ack1",     32'(bus.host_ack),  32'd1);
    chk("b2b_dout1",    32'(bus.host_dout), 32'h1111);
    bus.host_addr = 11'h041;
    #1;
    chk("b2b_masked",   32'(bus.ram_addr),  32'h040);
    chk("b2b_mask_we",  32'(bus.ram_we),    32'd0);
    tick();
    chk("b2b_no_dup",   32'(bus.host_ack),  32'd0);
    tick();
    chk("b2b_grant2",   32'(bus.ram_addr),  32'h041);
    tick();
    chk("b2b_gap_ack",  32'(bus.host_ack),  32'd0);
    tick();
    chk("b2b_ack2",     32'(bus.host_ack),  32'd1);
    chk("b2b_dout2",    32'(bus.host_dout), 32'h2222);
    bus.host_req = 1'b0;
    tick();
    chk("b2b_ack_end",  32'(bus.host_ack),  32'd0);

    // Reset while a host read waits for capture
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 11'h030;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_ack",    32'(bus.host_ack),  32'd0);
    chk("mid_rst_hdout",  32'(bus.host_dout), 32'd0);
    chk("mid_rst_xdout",  32'(bus.xa_dout),   32'd0);
    chk("mid_rst_ydout",  32'(bus.yb_dout),   32'd0);
    chk("mid_rst_cendiv", 32'(bus.cendiv),    32'd0);
    chk("mid_rst_we",     32'(bus.ram_we),    32'd0);
    chk("mid_rst_addr",   32'(bus.ram_addr),  32'd0);
    chk("mid_rst_din",    32'(bus.ram_din),   32'd0);
    rst = 1'b0;
    bus.host_req = 1'b0;
    tick();
    chk("restart_cendiv0", 32'(bus.cendiv),   32'd0);
    chk("restart_ack",     32'(bus.host_ack), 32'd0);
    tick();
    chk("restart_cendiv1", 32'(bus.cendiv),   32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
